// File: rtl/hpc2_rand_pkg.sv
// Shared constants and FSM encoding for the HPC2 randomness source.
// Holds the LFSR geometry, warmup length, zero-seed substitute and health threshold.
package hpc2_rand_pkg;

    localparam int LFSR_W        = 32;
    localparam int TAP_A         = 31;
    localparam int TAP_B         = 21;
    localparam int TAP_C         = 1;
    localparam int TAP_D         = 0;
    localparam int STEPS_PER_ADV = 6;
    localparam int WARMUP_ADV    = 8;
    localparam int HEALTH_THRESH = 16;

    localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 32'h0000_0001;

    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_WARMUP   = 2'd1,
        ST_RUN      = 2'd2
    } rand_state_t;

endpackage

// File: rtl/hpc2_lfsr_step.sv
// Combinational 6-step unroll of the 32-bit Fibonacci LFSR (taps 31,21,1,0).
// Zero latency; no flow control.
module hpc2_lfsr_step
    import hpc2_rand_pkg::*;
(
    input  logic [LFSR_W-1:0] s_cur,
    output logic [LFSR_W-1:0] s_next
);

    always_comb begin
        s_next = s_cur;
        for (int i = 0; i < STEPS_PER_ADV; i++) begin
            s_next = {s_next[LFSR_W-2:0],
                      s_next[TAP_A] ^ s_next[TAP_B] ^ s_next[TAP_C] ^ s_next[TAP_D]};
        end
    end

endmodule

// File: rtl/hpc2_rand_source.sv
// Seeded LFSR feeding six fresh bits per advance to a 4-share HPC2 AND; valid 9 cycles after seeding.
// Advances only on io_en once running; seed always accepted outside reset; HPC2_RAND_HEALTH_EN adds a repetition alarm.
module hpc2_rand_source
    import hpc2_rand_pkg::*;
(
    input  logic        clock_0,
    input  logic        reset_0,
    input  logic        io_seed_valid,
    input  logic [31:0] io_seed,
    output logic        io_seed_ready,
    input  logic        io_en,
    output logic        p_rand_0,
    output logic        p_rand_1,
    output logic        p_rand_2,
    output logic        p_rand_3,
    output logic        p_rand_4,
    output logic        p_rand_5,
    output logic        io_rand_valid,
    output logic        io_err
);

    rand_state_t       state;
    logic [LFSR_W-1:0] s;
    logic [LFSR_W-1:0] step_next;
    logic [2:0]        warm_cnt;
    logic              seed_hs;
    logic              adv;
    logic              run_adv;

    assign io_seed_ready = ~reset_0;
    assign seed_hs       = io_seed_valid & io_seed_ready;
    assign run_adv       = (state == ST_RUN) & io_en;
    assign adv           = (state == ST_WARMUP) | run_adv;

    hpc2_lfsr_step u_step (
        .s_cur  (s),
        .s_next (step_next)
    );

    // A handshake outranks any pending advance so a reseed always restarts warmup cleanly.
    always_ff @(posedge clock_0) begin
        if (reset_0) begin
            state    <= ST_UNSEEDED;
            s        <= '0;
            warm_cnt <= '0;
        end else if (seed_hs) begin
            state    <= ST_WARMUP;
            s        <= (io_seed == '0) ? ZERO_SEED_SUB : io_seed;
            warm_cnt <= '0;
        end else begin
            if (adv) begin
                s <= step_next;
            end
            if (state == ST_WARMUP) begin
                warm_cnt <= warm_cnt + 3'd1;
                if (warm_cnt == 3'(WARMUP_ADV - 1)) begin
                    state <= ST_RUN;
                end
            end
        end
    end

`ifdef HPC2_RAND_HEALTH_EN
    logic [4:0] rep_cnt;
    logic       err;

    // Counts consecutive running advances that reproduce the same six output bits.
    always_ff @(posedge clock_0) begin
        if (reset_0 || seed_hs) begin
            rep_cnt <= '0;
            err     <= 1'b0;
        end else if (run_adv) begin
            if (step_next[5:0] == s[5:0]) begin
                if (rep_cnt != 5'd31) begin
                    rep_cnt <= rep_cnt + 5'd1;
                end
                if (rep_cnt == 5'(HEALTH_THRESH - 1)) begin
                    err <= 1'b1;
                end
            end else begin
                rep_cnt <= '0;
            end
        end
    end

    assign io_err = err;
`else
    assign io_err = 1'b0;
`endif

    assign io_rand_valid = (state == ST_RUN) & ~io_err;

    assign p_rand_0 = io_rand_valid & s[0];
    assign p_rand_1 = io_rand_valid & s[1];
    assign p_rand_2 = io_rand_valid & s[2];
    assign p_rand_3 = io_rand_valid & s[3];
    assign p_rand_4 = io_rand_valid & s[4];
    assign p_rand_5 = io_rand_valid & s[5];

endmodule

// File: tb/tb_hpc2_rand_source.sv
// Directed bench for hpc2_rand_source: reset, seeding, warmup timing, stream model, io_en gating, reseed/reset.
// Define HPC2_RAND_HEALTH_EN to also exercise the repetition alarm.
module tb_hpc2_rand_source;

    logic        clock_0 = 1'b0;
    logic        reset_0 = 1'b1;
    logic        io_seed_valid = 1'b0;
    logic [31:0] io_seed = 32'h0;
    logic        io_en = 1'b0;
    logic        io_seed_ready;
    logic        p_rand_0, p_rand_1, p_rand_2, p_rand_3, p_rand_4, p_rand_5;
    logic        io_rand_valid;
    logic        io_err;

    logic [5:0]  prand;
    logic [31:0] model_s;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    assign prand = {p_rand_5, p_rand_4, p_rand_3, p_rand_2, p_rand_1, p_rand_0};

    always #5 clock_0 = ~clock_0;

    hpc2_rand_source dut (
        .clock_0       (clock_0),
        .reset_0       (reset_0),
        .io_seed_valid (io_seed_valid),
        .io_seed       (io_seed),
        .io_seed_ready (io_seed_ready),
        .io_en         (io_en),
        .p_rand_0      (p_rand_0),
        .p_rand_1      (p_rand_1),
        .p_rand_2      (p_rand_2),
        .p_rand_3      (p_rand_3),
        .p_rand_4      (p_rand_4),
        .p_rand_5      (p_rand_5),
        .io_rand_valid (io_rand_valid),
        .io_err        (io_err)
    );

    function automatic logic [31:0] golden6(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < 6; i++) begin
            t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
        end
        return t;
    endfunction

    task automatic tick();
        @(posedge clock_0);
        #1;
    endtask

    task automatic offer_seed(input logic [31:0] seed);
        io_seed_valid = 1'b1;
        io_seed       = seed;
        tick();
        io_seed_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_0       = 1'b1;
        io_seed_valid = 1'b1;
        io_seed       = 32'hACE1ACE1;
        io_en         = 1'b1;
        tick();
        tick();
        vec_cnt++;
        if ({io_seed_ready, io_rand_valid, prand, io_err} !== 9'b0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %b required %b",
                     {io_seed_ready, io_rand_valid, prand, io_err}, 9'b0);
        end
        reset_0       = 1'b0;
        io_seed_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            vec_cnt++;
            if ({io_seed_ready, io_rand_valid, prand, io_err} !== 9'b1_0_000000_0) begin
                err_cnt++;
                $display("FAIL unseeded_idle cyc %0d: got %b required %b", i,
                         {io_seed_ready, io_rand_valid, prand, io_err}, 9'b1_0_000000_0);
            end
        end
    endtask

    task automatic test_seed_stream(input logic [31:0] seed, input logic [31:0] load, input int ncyc);
        io_en = 1'b1;
        offer_seed(seed);
        model_s = load;
        for (int i = 0; i < 8; i++) begin
            vec_cnt++;
            if ({io_rand_valid, prand} !== 7'b0) begin
                err_cnt++;
                $display("FAIL warmup_quiet seed %h cyc %0d: got %b required %b",
                         seed, i + 1, {io_rand_valid, prand}, 7'b0);
            end
            model_s = golden6(model_s);
            tick();
        end
        vec_cnt++;
        if ({io_rand_valid, prand} !== {1'b1, model_s[5:0]}) begin
            err_cnt++;
            $display("FAIL first_valid seed %h: got %b required %b",
                     seed, {io_rand_valid, prand}, {1'b1, model_s[5:0]});
        end
        for (int i = 0; i < ncyc; i++) begin
            tick();
            model_s = golden6(model_s);
            vec_cnt++;
            if ({io_rand_valid, prand} !== {1'b1, model_s[5:0]}) begin
                err_cnt++;
                $display("FAIL stream seed %h cyc %0d: got %b required %b",
                         seed, i, {io_rand_valid, prand}, {1'b1, model_s[5:0]});
            end
        end
    endtask

    task automatic test_en_pattern();
        logic [3:0] pat;
        pat = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            io_en = pat[3-i];
            tick();
            if (pat[3-i]) model_s = golden6(model_s);
            vec_cnt++;
            if ({io_rand_valid, prand} !== {1'b1, model_s[5:0]}) begin
                err_cnt++;
                $display("FAIL en_gate step %0d en %b: got %b required %b",
                         i, pat[3-i], {io_rand_valid, prand}, {1'b1, model_s[5:0]});
            end
        end
        io_en = 1'b1;
    endtask

    task automatic test_reseed_reset();
        offer_seed(32'h12345678);
        vec_cnt++;
        if (io_rand_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL reseed_drop: got %b required 0", io_rand_valid);
        end
        tick();
        tick();
        tick();
        vec_cnt++;
        if ({io_rand_valid, prand} !== 7'b0) begin
            err_cnt++;
            $display("FAIL mid_warmup: got %b required %b", {io_rand_valid, prand}, 7'b0);
        end
        reset_0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vec_cnt++;
            if ({io_seed_ready, io_rand_valid, prand, io_err} !== 9'b0) begin
                err_cnt++;
                $display("FAIL reset_in_warmup cyc %0d: got %b required %b", i,
                         {io_seed_ready, io_rand_valid, prand, io_err}, 9'b0);
            end
        end
        reset_0 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            vec_cnt++;
            if ({io_seed_ready, io_rand_valid, prand} !== 8'b1_0_000000) begin
                err_cnt++;
                $display("FAIL back_to_unseeded cyc %0d: got %b required %b", i,
                         {io_seed_ready, io_rand_valid, prand}, 8'b1_0_000000);
            end
        end
    endtask

    task automatic test_back_to_back();
        offer_seed(32'h0BADF00D);
        tick();
        tick();
        tick();
        test_seed_stream(32'hCAFEF00D, 32'hCAFEF00D, 20);
    endtask

    task automatic test_reset_mid_run();
        reset_0 = 1'b1;
        tick();
        vec_cnt++;
        if ({io_seed_ready, io_rand_valid, prand, io_err} !== 9'b0) begin
            err_cnt++;
            $display("FAIL reset_in_run: got %b required %b",
                     {io_seed_ready, io_rand_valid, prand, io_err}, 9'b0);
        end
        reset_0 = 1'b0;
        tick();
        tick();
        vec_cnt++;
        if ({io_rand_valid, prand} !== 7'b0) begin
            err_cnt++;
            $display("FAIL after_reset_run: got %b required %b", {io_rand_valid, prand}, 7'b0);
        end
    endtask

`ifdef HPC2_RAND_HEALTH_EN
    task automatic test_health();
        int n;
        test_seed_stream(32'h00000001, 32'h00000001, 4);
        io_en = 1'b1;
        force dut.step_next = 32'hDEADBEEF;
        n = 0;
        while (io_err !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        vec_cnt++;
        if (io_err !== 1'b1 || n < 16 || n > 17) begin
            err_cnt++;
            $display("FAIL health_alarm: err %b after %0d advances, required 1 after 16..17", io_err, n);
        end
        vec_cnt++;
        if ({io_rand_valid, prand} !== 7'b0) begin
            err_cnt++;
            $display("FAIL health_mask: got %b required %b", {io_rand_valid, prand}, 7'b0);
        end
        release dut.step_next;
        offer_seed(32'h00000001);
        vec_cnt++;
        if (io_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL health_clear: got %b required 0", io_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_seed_stream(32'hACE1ACE1, 32'hACE1ACE1, 1000);
        test_en_pattern();
        test_reseed_reset();
        test_seed_stream(32'h00000000, 32'h00000001, 64);
        test_back_to_back();
        test_reset_mid_run();
`ifdef HPC2_RAND_HEALTH_EN
        test_health();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
